// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-and-add unsigned multiplier with start/busy/done handshake
// Optional MULT_EARLY_EXIT_EN: leave CALC as soon as no set multiplier bits remain.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module shift_add_multiplier #(
  parameter int A_WIDTH = 2,
  parameter int B_WIDTH = 3,
  parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [P_WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(B_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(B_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic [P_WIDTH-1:0] mcand_q, mcand_d;
  logic [B_WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [P_WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               last_step;

  logic [P_WIDTH-1:0] sum;
  logic [P_WIDTH-1:0] carry;
  logic               carry_unused;

  // The carry out of the top cell can never be set: P_WIDTH bits hold the largest product.
  assign carry[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < P_WIDTH; i++) begin : g_ripple
      if (i < P_WIDTH - 1) begin : g_mid
        full_adder u_fa (
          .a    (acc_q[i]),
          .b    (mcand_q[i]),
          .cin  (carry[i]),
          .sum  (sum[i]),
          .cout (carry[i+1])
        );
      end else begin : g_top
        full_adder u_fa (
          .a    (acc_q[i]),
          .b    (mcand_q[i]),
          .cin  (carry[i]),
          .sum  (sum[i]),
          .cout (carry_unused)
        );
      end
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    last_step = 1'b0;

    case (state_q)
      CALC: begin
        acc_d    = mplier_q[0] ? sum : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef MULT_EARLY_EXIT_EN
        last_step = (cnt_q == LAST_STEP) || (mplier_d == '0);
`else
        last_step = (cnt_q == LAST_STEP);
`endif
        if (last_step) begin
          product_d = acc_d;
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE accept a new request identically, so DONE can chain straight into CALC.
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          acc_d    = '0;
          mcand_d  = P_WIDTH'(a);
          mplier_d = b;
          cnt_d    = '0;
          state_d  = CALC;
          busy_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - randomized self-checking bench for shift_add_multiplier

module tb_shift_add_multiplier;

  localparam int A_W = 2;
  localparam int B_W = 3;
  localparam int P_W = A_W + B_W;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           busy;
  logic           done;
  logic [P_W-1:0] product;

  int vectors     = 0;
  int miscompares = 0;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Number of CALC cycles the reference expects for multiplier value bv.
  function automatic int exp_calc_cycles(input int bv);
`ifdef MULT_EARLY_EXIT_EN
    int n = 1;
    for (int k = 0; k < B_W; k++)
      if (bv[k]) n = k + 1;
    return n;
`else
    return B_W + 0 * bv;
`endif
  endfunction

  // Called at the first negedge after the accepting edge; returns at the done cycle's negedge.
  task automatic wait_done(input string tag, input bit noise, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        a     = A_W'($urandom);
        b     = B_W'($urandom);
      end
      cycles++;
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input int av, input int bv, input bit noise);
    int cyc;
    a     = A_W'(av);
    b     = B_W'(bv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag, noise, cyc);
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(exp_calc_cycles(bv)));
    check({tag, "_product"}, 32'(product), 32'(av * bv));
    @(negedge clk);
    check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(product), 32'(av * bv));
  endtask

  initial begin
    int cyc;
    int av;
    int bv;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("basic_3x7", 3, 7, 1'b0);

    for (int ai = 0; ai < (1 << A_W); ai++)
      for (int bi = 0; bi < (1 << B_W); bi++)
        run_op("sweep", ai, bi, 1'b0);

    for (int n = 0; n < 24; n++) begin
      av = int'($urandom_range(0, (1 << A_W) - 1));
      bv = int'($urandom_range(0, (1 << B_W) - 1));
      run_op("random_noisy", av, bv, 1'b1);
    end

    // Back-to-back with start held high.
    a     = 2'd2;
    b     = 3'd5;
    start = 1'b1;
    @(negedge clk);
    wait_done("b2b_first", 1'b0, cyc);
    check("b2b_first_product", 32'(product), 32'd10);
    a = 2'd1;
    b = 3'd6;
    @(negedge clk);
    check("b2b_no_idle", 32'(busy), 32'd1);
    wait_done("b2b_second", 1'b0, cyc);
    start = 1'b0;
    check("b2b_done_spacing", 32'(cyc + 1), 32'(exp_calc_cycles(6) + 1));
    check("b2b_second_product", 32'(product), 32'd6);
    @(negedge clk);
    check("b2b_done_once", 32'(done), 32'd0);

    // Mid-CALC start and operand changes must be ignored.
    a     = 2'd3;
    b     = 3'd7;
    start = 1'b1;
    @(negedge clk);
    a     = 2'd0;
    b     = 3'd0;
    wait_done("ignore", 1'b0, cyc);
    start = 1'b0;
    check("ignore_product", 32'(product), 32'd21);
    @(negedge clk);

    // Asynchronous reset during the second CALC cycle.
    a     = 2'd3;
    b     = 3'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_product", 32'(product), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 32'd0);
      check("post_rst_no_busy", 32'(busy), 32'd0);
    end
    run_op("after_rst_1x1", 1, 1, 1'b0);

    run_op("exit_3x1", 3, 1, 1'b0);
    run_op("exit_3x4", 3, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
